// File: rtl/alu_arbiter_if.sv
// Requester and response channels between two ALU clients and the shared-ALU arbiter.
`timescale 1ns/1ps
interface alu_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one operation in flight,
// operands held for ALU_LATENCY cycles, tagged response with back-pressure.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int WIDTH       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry
);
    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ALU_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             gnt;
    logic             accept;
    logic             capture;
    logic             rsp_done;

    // Carry is only meaningful for add; every other opcode reports 0.
    function automatic logic mask_carry(input logic [1:0] op, input logic c);
        return (op == 2'b00) && c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        gnt            = 1'b0;
        accept         = 1'b0;
        capture        = 1'b0;
        rsp_done       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state)
            IDLE: begin
                // On contention the requester that did not win last time goes first.
                if (bus.req0_valid && bus.req1_valid) gnt = ~last_grant;
                else                                  gnt = bus.req1_valid;
                bus.req0_ready = rst_n && !gnt && bus.req0_valid;
                bus.req1_ready = rst_n &&  gnt && bus.req1_valid;
                accept         = bus.req0_ready || bus.req1_ready;
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (cnt == LAST) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a          <= '0;
            alu_b          <= '0;
            alu_op         <= 2'b00;
            bus.rsp_result <= '0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            last_grant     <= 1'b1;
            cnt            <= '0;
        end else begin
            if (accept) begin
                alu_a      <= gnt ? bus.req1_a  : bus.req0_a;
                alu_b      <= gnt ? bus.req1_b  : bus.req0_b;
                alu_op     <= gnt ? bus.req1_op : bus.req0_op;
                bus.rsp_id <= gnt;
                last_grant <= gnt;
                cnt        <= '0;
            end else if (state == ISSUE) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (capture) begin
                bus.rsp_result <= alu_result;
                bus.rsp_zero   <= alu_zero;
                bus.rsp_carry  <= mask_carry(alu_op, alu_carry);
                bus.rsp_valid  <= 1'b1;
            end else if (rsp_done) begin
                bus.rsp_valid  <= 1'b0;
            end
        end
    end

    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: two instances (latency 1 and 3), each driving a behavioural 4-bit ALU.
`timescale 1ns/1ps
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    alu_arbiter_if #(.WIDTH(4)) bus1 ();
    alu_arbiter_if #(.WIDTH(4)) bus3 ();

    logic [3:0] alu1_a, alu1_b, alu1_result, alu3_a, alu3_b, alu3_result;
    logic [1:0] alu1_op, alu3_op;
    logic       alu1_zero, alu1_carry, alu3_zero, alu3_carry;

    // Behavioural ALU: sub carry is the no-borrow bit so carry masking is observable.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} + {1'b0, ~b} + 5'd1;
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign {alu1_carry, alu1_result} = alu_f(alu1_a, alu1_b, alu1_op);
    assign alu1_zero = (alu1_result == 4'd0);
    assign {alu3_carry, alu3_result} = alu_f(alu3_a, alu3_b, alu3_op);
    assign alu3_zero = (alu3_result == 4'd0);

    alu_arbiter #(.WIDTH(4), .ALU_LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .alu_a(alu1_a), .alu_b(alu1_b), .alu_op(alu1_op),
        .alu_result(alu1_result), .alu_zero(alu1_zero), .alu_carry(alu1_carry)
    );

    alu_arbiter #(.WIDTH(4), .ALU_LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3),
        .alu_a(alu3_a), .alu_b(alu3_b), .alu_op(alu3_op),
        .alu_result(alu3_result), .alu_zero(alu3_zero), .alu_carry(alu3_carry)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_rsp1(input string tag, input logic id, input logic [3:0] res,
                            input logic z, input logic c);
        chk({tag, "_valid"},  32'(bus1.rsp_valid),  32'd1);
        chk({tag, "_id"},     32'(bus1.rsp_id),     32'(id));
        chk({tag, "_result"}, 32'(bus1.rsp_result), 32'(res));
        chk({tag, "_zero"},   32'(bus1.rsp_zero),   32'(z));
        chk({tag, "_carry"},  32'(bus1.rsp_carry),  32'(c));
    endtask

    initial begin
        bus1.req0_valid = 0; bus1.req0_a = 0; bus1.req0_b = 0; bus1.req0_op = 0;
        bus1.req1_valid = 0; bus1.req1_a = 0; bus1.req1_b = 0; bus1.req1_op = 0;
        bus1.rsp_ready  = 0;
        bus3.req0_valid = 0; bus3.req0_a = 0; bus3.req0_b = 0; bus3.req0_op = 0;
        bus3.req1_valid = 0; bus3.req1_a = 0; bus3.req1_b = 0; bus3.req1_op = 0;
        bus3.rsp_ready  = 0;

        // Reset state
        cyc(); cyc();
        chk("rst_alu_a", 32'(alu1_a), 0);
        chk("rst_alu_op", 32'(alu1_op), 0);
        chk("rst_rsp_valid", 32'(bus1.rsp_valid), 0);
        chk("rst_busy", 32'(bus1.busy), 0);
        chk("rst_rsp_result", 32'(bus1.rsp_result), 0);
        bus1.req0_valid = 1;
        #1 chk("rst_ready0_forced", 32'(bus1.req0_ready), 0);
        bus1.req0_valid = 0;
        rst_n = 1;

        // Test 1: req0 add 5+3
        cyc();
        bus1.req0_valid = 1; bus1.req0_a = 4'd5; bus1.req0_b = 4'd3; bus1.req0_op = 2'b00;
        bus1.rsp_ready = 1;
        #1 chk("t1_ready0", 32'(bus1.req0_ready), 1);
        chk("t1_ready1", 32'(bus1.req1_ready), 0);
        cyc();
        bus1.req0_valid = 0;
        chk("t1_busy_issue", 32'(bus1.busy), 1);
        chk("t1_valid_issue", 32'(bus1.rsp_valid), 0);
        chk("t1_alu_a", 32'(alu1_a), 5);
        chk("t1_alu_b", 32'(alu1_b), 3);
        cyc();
        chk_rsp1("t1_rsp", 1'b0, 4'h8, 1'b0, 1'b0);
        chk("t1_busy_resp", 32'(bus1.busy), 1);
        cyc();
        chk("t1_valid_done", 32'(bus1.rsp_valid), 0);
        chk("t1_busy_done", 32'(bus1.busy), 0);

        // Test 2: req1 add overflow, then sub with carry masked
        bus1.req1_valid = 1; bus1.req1_a = 4'd9; bus1.req1_b = 4'd7; bus1.req1_op = 2'b00;
        #1 chk("t2_ready1", 32'(bus1.req1_ready), 1);
        chk("t2_ready0", 32'(bus1.req0_ready), 0);
        cyc(); bus1.req1_valid = 0;
        cyc();
        chk_rsp1("t2_add", 1'b1, 4'h0, 1'b1, 1'b1);
        cyc();
        bus1.req1_valid = 1; bus1.req1_a = 4'd3; bus1.req1_b = 4'd3; bus1.req1_op = 2'b01;
        cyc(); bus1.req1_valid = 0;
        cyc();
        chk_rsp1("t2_sub", 1'b1, 4'h0, 1'b1, 1'b0);
        cyc();

        // Test 3: continuous contention after reset alternates 0,1,0,1
        rst_n = 0; cyc(); rst_n = 1;
        bus1.req0_valid = 1; bus1.req0_a = 4'hC; bus1.req0_b = 4'hA; bus1.req0_op = 2'b10;
        bus1.req1_valid = 1; bus1.req1_a = 4'hA; bus1.req1_b = 4'h5; bus1.req1_op = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t3_ready0", 32'(bus1.req0_ready), (k % 2 == 0) ? 1 : 0);
            chk("t3_ready1", 32'(bus1.req1_ready), (k % 2 == 0) ? 0 : 1);
            cyc();
            chk("t3_issue_ready0", 32'(bus1.req0_ready), 0);
            chk("t3_issue_ready1", 32'(bus1.req1_ready), 0);
            cyc();
            chk_rsp1("t3_rsp", (k % 2 == 1), (k % 2 == 0) ? 4'h8 : 4'hF, 1'b0, 1'b0);
            chk("t3_resp_ready1", 32'(bus1.req1_ready), 0);
            cyc();
        end

        // Test 4: back-pressure, req0 add F+2
        bus1.req1_valid = 0;
        bus1.req0_a = 4'hF; bus1.req0_b = 4'h2; bus1.req0_op = 2'b00;
        bus1.rsp_ready = 0;
        #1 chk("t4_ready0", 32'(bus1.req0_ready), 1);
        cyc();
        bus1.req0_valid = 0;
        cyc();
        bus1.req0_valid = 1; bus1.req1_valid = 1;
        for (int k = 0; k < 5; k++) begin
            #1 chk_rsp1("t4_hold", 1'b0, 4'h1, 1'b0, 1'b1);
            chk("t4_hold_alu_a", 32'(alu1_a), 32'hF);
            chk("t4_hold_alu_b", 32'(alu1_b), 32'h2);
            chk("t4_hold_ready0", 32'(bus1.req0_ready), 0);
            chk("t4_hold_ready1", 32'(bus1.req1_ready), 0);
            chk("t4_hold_busy", 32'(bus1.busy), 1);
            cyc();
        end
        bus1.rsp_ready = 1;
        #1 chk("t4_done_ready0", 32'(bus1.req0_ready), 0);
        chk("t4_done_ready1", 32'(bus1.req1_ready), 0);
        cyc();
        chk("t4_idle_valid", 32'(bus1.rsp_valid), 0);
        chk("t4_idle_busy", 32'(bus1.busy), 0);
        #1 chk("t4_next_ready1", 32'(bus1.req1_ready), 1);
        chk("t4_next_ready0", 32'(bus1.req0_ready), 0);

        // Test 5: reset during ISSUE discards the operation
        cyc();
        chk("t5_busy_issue", 32'(bus1.busy), 1);
        rst_n = 0; bus1.req0_valid = 0; bus1.req1_valid = 0;
        cyc();
        chk("t5_alu_a", 32'(alu1_a), 0);
        chk("t5_alu_b", 32'(alu1_b), 0);
        chk("t5_alu_op", 32'(alu1_op), 0);
        chk("t5_rsp_valid", 32'(bus1.rsp_valid), 0);
        chk("t5_rsp_id", 32'(bus1.rsp_id), 0);
        chk("t5_rsp_result", 32'(bus1.rsp_result), 0);
        chk("t5_busy", 32'(bus1.busy), 0);
        bus1.req0_a = 4'hC; bus1.req0_b = 4'hA; bus1.req0_op = 2'b10;
        bus1.req0_valid = 1; bus1.req1_valid = 1;
        #1 chk("t5_rst_ready0", 32'(bus1.req0_ready), 0);
        chk("t5_rst_ready1", 32'(bus1.req1_ready), 0);
        rst_n = 1;
        #1 chk("t5_first_ready0", 32'(bus1.req0_ready), 1);
        chk("t5_first_ready1", 32'(bus1.req1_ready), 0);
        chk("t5_no_rsp", 32'(bus1.rsp_valid), 0);
        cyc();
        bus1.req0_valid = 0; bus1.req1_valid = 0;
        cyc();
        chk_rsp1("t5_rsp", 1'b0, 4'h8, 1'b0, 1'b0);
        cyc();

        // Test 6: ALU_LATENCY=3, 1+2
        bus3.req0_valid = 1; bus3.req0_a = 4'd1; bus3.req0_b = 4'd2; bus3.req0_op = 2'b00;
        bus3.rsp_ready = 1;
        #1 chk("t6_ready0", 32'(bus3.req0_ready), 1);
        cyc();
        bus3.req0_valid = 0;
        for (int k = 0; k < 3; k++) begin
            chk("t6_alu_a", 32'(alu3_a), 1);
            chk("t6_alu_b", 32'(alu3_b), 2);
            chk("t6_alu_op", 32'(alu3_op), 0);
            chk("t6_no_valid", 32'(bus3.rsp_valid), 0);
            chk("t6_busy", 32'(bus3.busy), 1);
            cyc();
        end
        chk("t6_valid", 32'(bus3.rsp_valid), 1);
        chk("t6_result", 32'(bus3.rsp_result), 3);
        chk("t6_id", 32'(bus3.rsp_id), 0);
        chk("t6_carry", 32'(bus3.rsp_carry), 0);
        chk("t6_zero", 32'(bus3.rsp_zero), 0);
        cyc();
        chk("t6_done", 32'(bus3.rsp_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
